// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit and receive engines.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronizes rx, validates the start bit at half-bit, samples data mid-bit.
import uart_pkg::*;

module uart_rx #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready
);

    localparam int            CW   = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);

    uart_state_e          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic [7:0]           data_n;
    logic                 rdy_n;
    logic                 rx_s1, rx_s2, rx_q;
    logic                 fall;

    // A falling edge needs the line seen high first, so a held-low line never re-arms.
    assign fall = rx_q & ~rx_s2;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        data_n  = rx_data;
        rdy_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (fall) state_n = ST_START;
            end
            ST_START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s2 ? ST_IDLE : ST_DATA;
                end else cnt_n = cnt + 1'b1;
            end
            ST_DATA: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    sh_n  = {rx_s2, sh[DATA_BITS-1:1]};
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) state_n = ST_STOP;
                end else cnt_n = cnt + 1'b1;
            end
            ST_STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    if (rx_s2) begin
                        data_n = sh;
                        rdy_n  = 1'b1;
                    end
                end else cnt_n = cnt + 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_q     <= 1'b1;
            state    <= ST_IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            rx_data  <= 8'h00;
            rx_ready <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_q     <= rx_s2;
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            sh       <= sh_n;
            rx_data  <= data_n;
            rx_ready <= rdy_n;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, eight data bits LSB first, stop bit, CLK_PER_BIT clocks each.
import uart_pkg::*;

module uart_tx #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);

    localparam int            CW   = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    uart_state_e          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 tx_n, busy_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (tx_start) begin
                    sh_n    = tx_data;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = ST_DATA;
                end else cnt_n = cnt + 1'b1;
            end
            ST_DATA: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    sh_n  = sh >> 1;
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) state_n = ST_STOP;
                end else cnt_n = cnt + 1'b1;
            end
            ST_STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else cnt_n = cnt + 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase

        // Pin values are decoded from the next state so tx and tx_busy come straight off flops.
        busy_n = (state_n != ST_IDLE);
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = sh_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sh      <= sh_n;
            tx      <= tx_n;
            tx_busy <= busy_n;
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// UART transceiver top: independent TX and RX engines on one clock.
import uart_pkg::*;

module uart_txrx #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready
);

    uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed + randomized bench for uart_txrx with a frame-level reference model.
module tb_uart_txrx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx, tx_busy;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       lb;
    logic       rx_drv;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got[$];
    logic       prev_rdy = 1'b0;

    always #10 clk = ~clk;

    assign rx_line = lb ? tx : rx_drv;

    uart_txrx #(.CLK_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .rx       (rx_line),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial line value of bit k (0..9) of an 8N1 frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return d[k-1];
    endfunction

    // Received bytes in arrival order; each pulse must last exactly one cycle.
    always @(negedge clk) begin
        if (rx_ready) begin
            got.push_back(rx_data);
            checks++;
            assert (prev_rdy === 1'b0) else begin
                errors++;
                $error("FAIL rdy_width: observed %0h expected %0h", prev_rdy, 1'b0);
            end
        end
        prev_rdy = rx_ready;
    end

    // Caller has tx_start=1 and tx_data=d set; the next edge launches the frame.
    task automatic run_frame(input logic [7:0] d, input bit chain, input logic [7:0] nxt,
                             input bit poke);
        @(posedge clk); #1;
        for (int c = 0; c <= 10 * CPB; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == 0 || c == 31) tx_start = 1'b0;
            if (c == 30 && poke) tx_start = 1'b1;
            if (c < 10 * CPB - 1) tx_data = 8'($urandom);
            if (c % CPB == CPB / 2) check("tx_bit", tx, frame_bit(d, c / CPB));
            if (c == 0 || c == 10 * CPB - 1) check("busy_hi", tx_busy, 1'b1);
            if (c == 10 * CPB) begin
                check("busy_lo", tx_busy, 1'b0);
                check("tx_idle", tx, 1'b1);
            end
            if (c == 10 * CPB - 1 && chain) begin
                tx_start = 1'b1;
                tx_data  = nxt;
            end
        end
    endtask

    task automatic expect_rx(input logic [7:0] b);
        check("rx_count", got.size(), 1);
        if (got.size() >= 1) check("rx_byte", got[0], b);
        check("rx_data", rx_data, b);
        got.delete();
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        for (int k = 0; k < 10; k++) begin
            rx_drv = (k == 9) ? stop : frame_bit(d, k);
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] seq[3];
        seq = '{8'h00, 8'hFF, 8'h55};
        lb = 1'b1; rx_drv = 1'b1; rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00;

        repeat (5) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_rdy", rx_ready, 1'b0);
        check("rst_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        tx_data = 8'hAB; tx_start = 1'b1;
        run_frame(8'hAB, 1'b0, 8'h00, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        expect_rx(8'hAB);

        tx_data = seq[0]; tx_start = 1'b1;
        run_frame(seq[0], 1'b1, seq[1], 1'b0);
        run_frame(seq[1], 1'b1, seq[2], 1'b0);
        run_frame(seq[2], 1'b0, 8'h00, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            if (got.size() > i) check("b2b_byte", got[i], seq[i]);
        got.delete();

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            tx_data = b; tx_start = 1'b1;
            run_frame(b, 1'b0, 8'h00, 1'b0);
            repeat (5) @(posedge clk);
            #1;
            expect_rx(b);
        end

        tx_data = 8'hC3; tx_start = 1'b1;
        run_frame(8'hC3, 1'b0, 8'h00, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("poke_idle", tx_busy, 1'b0);
        expect_rx(8'hC3);

        lb = 1'b0;
        rx_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_none", got.size(), 0);
        drive_frame(8'h3C, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        expect_rx(8'h3C);

        drive_frame(8'h96, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        check("frerr_none", got.size(), 0);
        check("frerr_keep", rx_data, 8'h3C);
        drive_frame(8'hA5, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        expect_rx(8'hA5);

        lb = 1'b1;
        tx_data = 8'($urandom); tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        check("mid_busy", tx_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", tx_busy, 1'b0);
        check("abort_data", rx_data, 8'h00);
        check("abort_rdy", rx_ready, 1'b0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        got.delete();

        b = 8'($urandom);
        tx_data = b; tx_start = 1'b1;
        run_frame(b, 1'b0, 8'h00, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        expect_rx(b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
